pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipeline_controller_scoreboard.sv | 54 +++++
 rtl/pipeline_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, register-file sizing and small decode helpers
// for the pipeline controller.
package pipe_ctrl_pkg;

   localparam int REG_IDX_W = 4;
   localparam int NUM_REGS  = 16;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_UNUSED   = 2'd3
   } state_t;

   function automatic logic is_mem_op(input logic rd_op, input logic wr_op);
      return rd_op | wr_op;
   endfunction

endpackage

// File: rtl/pipeline_controller_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register,
// with a writeback bypass on both read ports and set-over-clear priority.
module reg_scoreboard
   import pipe_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en,
   input  logic [REG_IDX_W-1:0] set_idx,
   input  logic                 clr_en,
   input  logic [REG_IDX_W-1:0] clr_idx,
   input  logic [REG_IDX_W-1:0] rd_idx_a,
   input  logic [REG_IDX_W-1:0] rd_idx_b,
   output logic                 busy_a,
   output logic                 busy_b
);

   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_view_s;
   logic [NUM_REGS-1:0] busy_next_s;

   // Busy bits as seen this cycle, with the retiring writeback already removed
   always_comb begin
      busy_view_s = busy_r;
      if (clr_en) begin
         busy_view_s[clr_idx] = 1'b0;
      end else begin
         busy_view_s = busy_r;
      end
   end

   // Next busy bits: a new producer overrides a same-register writeback
   always_comb begin
      busy_next_s = busy_view_s;
      if (set_en) begin
         busy_next_s[set_idx] = 1'b1;
      end else begin
         busy_next_s = busy_view_s;
      end
   end

   // Busy-bit storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= {NUM_REGS{1'b0}};
      end else begin
         busy_r <= busy_next_s;
      end
   end

   assign busy_a = busy_view_s[rd_idx_a];
   assign busy_b = busy_view_s[rd_idx_b];

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard, branch-flush and memory-wait controller.
// Define PIPE_CTRL_TIMEOUT_EN to build the mem_ack watchdog that drives mem_err.
module pipeline_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dec_valid,
   input  logic [3:0] dec_rs1,
   input  logic [3:0] dec_rs2,
   input  logic [1:0] dec_rs_used,
   input  logic [3:0] dec_rd,
   input  logic       dec_selWB,
   input  logic       dec_selMEMRD,
   input  logic       dec_selMEMWR,
   input  logic       wb_valid,
   input  logic [3:0] wb_rd,
   input  logic       br_taken,
   input  logic       mem_ack,
   output logic       issue,
   output logic       stall_if,
   output logic       stall_id,
   output logic       flush_id,
   output logic       flush_ex,
   output logic       mem_req,
   output logic       mem_err,
   output logic [1:0] state
);

   localparam logic [2:0] FLUSH_LAST   = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_r;
   state_t     state_next_s;
   logic [2:0] flush_cnt_r;
   logic [2:0] flush_cnt_next_s;
   logic       mem_req_r;
   logic       mem_err_r;
   logic       busy_rs1_s;
   logic       busy_rs2_s;
   logic       raw_s;
   logic       issue_s;
   logic       stall_s;
   logic       flush_s;
   logic       sb_set_s;
   logic       tmo_hit_s;

   reg_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (sb_set_s),
      .set_idx  (dec_rd),
      .clr_en   (wb_valid),
      .clr_idx  (wb_rd),
      .rd_idx_a (dec_rs1),
      .rd_idx_b (dec_rs2),
      .busy_a   (busy_rs1_s),
      .busy_b   (busy_rs2_s)
   );

   assign raw_s    = (dec_rs_used[0] & busy_rs1_s) | (dec_rs_used[1] & busy_rs2_s);
   assign sb_set_s = issue_s & dec_selWB;

`ifdef PIPE_CTRL_TIMEOUT_EN
   logic [7:0] tmo_cnt_r;

   // An ack on the last allowed cycle still completes the access normally
   assign tmo_hit_s = (state_r == ST_MEM_WAIT) && !mem_ack && (tmo_cnt_r == TIMEOUT_LAST);

   // Cycles spent waiting for mem_ack; cleared whenever not waiting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_r <= 8'd0;
      end else if ((state_r == ST_MEM_WAIT) && !mem_ack && !tmo_hit_s) begin
         tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
         tmo_cnt_r <= 8'd0;
      end
   end
`else
   // Without the watchdog MEM_TIMEOUT has no effect and nothing ever times out
   assign tmo_hit_s = 1'b0 & (TIMEOUT_LAST == 8'd0);
`endif

   // Next-state and combinational pipeline controls
   always_comb begin
      state_next_s     = state_r;
      flush_cnt_next_s = flush_cnt_r;
      issue_s          = 1'b0;
      stall_s          = 1'b0;
      flush_s          = 1'b0;
      case (state_r)
         ST_RUN: begin
            issue_s = dec_valid & ~raw_s & ~br_taken;
            stall_s = dec_valid & ~issue_s & ~br_taken;
            if (br_taken) begin
               state_next_s     = ST_FLUSH;
               flush_cnt_next_s = FLUSH_LAST;
            end else if (issue_s && is_mem_op(dec_selMEMRD, dec_selMEMWR)) begin
               state_next_s = ST_MEM_WAIT;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            flush_s = 1'b1;
            if (flush_cnt_r == 3'd0) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s     = ST_FLUSH;
               flush_cnt_next_s = flush_cnt_r - 3'd1;
            end
         end
         ST_MEM_WAIT: begin
            stall_s = 1'b1;
            if (mem_ack || tmo_hit_s) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_MEM_WAIT;
            end
         end
         default: begin
            state_next_s     = ST_RUN;
            flush_cnt_next_s = 3'd0;
         end
      endcase
   end

   // FSM state, flush counter and registered memory handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_RUN;
         flush_cnt_r <= 3'd0;
         mem_req_r   <= 1'b0;
         mem_err_r   <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         flush_cnt_r <= flush_cnt_next_s;
         mem_req_r   <= (state_next_s == ST_MEM_WAIT);
         mem_err_r   <= tmo_hit_s;
      end
   end

   assign issue    = issue_s;
   assign stall_if = stall_s;
   assign stall_id = stall_s;
   assign flush_id = flush_s;
   assign flush_ex = flush_s;
   assign mem_req  = mem_req_r;
   assign mem_err  = mem_err_r;
   assign state    = state_r;

endmodule
